// File: rtl/cache_ctrl_wb.sv
// Write-back, write-allocate, direct-mapped data-cache controller with a full-cache flush walk.
// Line fills and evictions move one 32-bit word per mem_req/mem_ack beat.
module cache_ctrl_wb #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned LINES          = 16,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [31:0]       cpu_rdata,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
);
  localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W - 2;
  localparam int unsigned WA_W  = ADDR_W - 2;

  typedef enum logic [2:0] {
    IDLE, TAG_CHECK, WRITEBACK, REFILL, FLUSH_SCAN, FLUSH_WB
  } state_t;

  state_t            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d, dirty_q, dirty_d;
  logic [WA_W-1:0]   waddr_q, waddr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [OFF_W-1:0]  beat_q, beat_d;
  logic [IDX_W-1:0]  fidx_q, fidx_d;
  logic [31:0]       hits_q, hits_d, misses_q, misses_d;
  logic              refilled_q, refilled_d;

  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [31:0]       data_q [LINES][WORDS_PER_LINE];

  logic              arr_we, tag_we;
  logic [IDX_W-1:0]  arr_idx;
  logic [OFF_W-1:0]  arr_off;
  logic [31:0]       arr_wdata;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [OFF_W-1:0]  req_off;
  logic              hit, last_beat, last_line;
  logic              unused_cpu_addr;

  assign req_tag         = waddr_q[WA_W-1 -: TAG_W];
  assign req_idx         = waddr_q[OFF_W +: IDX_W];
  assign req_off         = waddr_q[OFF_W-1:0];
  assign hit             = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign last_beat       = (beat_q == OFF_W'(WORDS_PER_LINE - 1));
  assign last_line       = (fidx_q == IDX_W'(LINES - 1));
  assign unused_cpu_addr = ^cpu_addr[1:0];

  assign cpu_ready   = (state_q == IDLE) && !flush_req;
  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;

  // Next-state, array-write and output decode
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    waddr_d    = waddr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    beat_d     = beat_q;
    fidx_d     = fidx_q;
    hits_d     = hits_q;
    misses_d   = misses_q;
    refilled_d = refilled_q;
    arr_we     = 1'b0;
    arr_idx    = req_idx;
    arr_off    = req_off;
    arr_wdata  = wdata_q;
    tag_we     = 1'b0;
    cpu_done   = 1'b0;
    flush_done = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cpu_rdata  = data_q[req_idx][req_off];

    unique case (state_q)
      IDLE: begin
        if (flush_req) begin
          fidx_d  = '0;
          state_d = FLUSH_SCAN;
        end else if (cpu_req) begin
          waddr_d    = cpu_addr[ADDR_W-1:2];
          we_d       = cpu_we;
          wdata_d    = cpu_wdata;
          refilled_d = 1'b0;
          state_d    = TAG_CHECK;
        end
      end
      TAG_CHECK: begin
        if (hit) begin
          cpu_done = 1'b1;
          if (we_q) begin
            arr_we           = 1'b1;
            dirty_d[req_idx] = 1'b1;
          end
          // The re-check after a refill was already counted as a miss
          if (!refilled_q && (hits_q != 32'hFFFF_FFFF)) hits_d = hits_q + 32'd1;
          state_d = IDLE;
        end else begin
          if (misses_q != 32'hFFFF_FFFF) misses_d = misses_q + 32'd1;
          beat_d  = '0;
          state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[req_idx], req_idx, beat_q, 2'b00};
        mem_wdata = data_q[req_idx][beat_q];
        if (mem_ack) begin
          beat_d = beat_q + OFF_W'(1);
          if (last_beat) state_d = REFILL;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, beat_q, 2'b00};
        if (mem_ack) begin
          arr_we    = 1'b1;
          arr_off   = beat_q;
          arr_wdata = mem_rdata;
          beat_d    = beat_q + OFF_W'(1);
          if (last_beat) begin
            tag_we           = 1'b1;
            valid_d[req_idx] = 1'b1;
            dirty_d[req_idx] = 1'b0;
            refilled_d       = 1'b1;
            state_d          = TAG_CHECK;
          end
        end
      end
      FLUSH_SCAN: begin
        if (valid_q[fidx_q] && dirty_q[fidx_q]) begin
          beat_d  = '0;
          state_d = FLUSH_WB;
        end else begin
          valid_d[fidx_q] = 1'b0;
          if (last_line) begin
            flush_done = 1'b1;
            state_d    = IDLE;
          end else begin
            fidx_d = fidx_q + IDX_W'(1);
          end
        end
      end
      FLUSH_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[fidx_q], fidx_q, beat_q, 2'b00};
        mem_wdata = data_q[fidx_q][beat_q];
        if (mem_ack) begin
          beat_d = beat_q + OFF_W'(1);
          if (last_beat) begin
            valid_d[fidx_q] = 1'b0;
            dirty_d[fidx_q] = 1'b0;
            if (last_line) begin
              flush_done = 1'b1;
              state_d    = IDLE;
            end else begin
              fidx_d  = fidx_q + IDX_W'(1);
              state_d = FLUSH_SCAN;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state; reset drops any half-filled line by clearing every valid bit
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      waddr_q    <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      beat_q     <= '0;
      fidx_q     <= '0;
      hits_q     <= '0;
      misses_q   <= '0;
      refilled_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      waddr_q    <= waddr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      beat_q     <= beat_d;
      fidx_q     <= fidx_d;
      hits_q     <= hits_d;
      misses_q   <= misses_d;
      refilled_q <= refilled_d;
    end
  end

  // Tag and data storage carry no reset
  always_ff @(posedge CLK) begin
    if (!RST && arr_we) data_q[arr_idx][arr_off] <= arr_wdata;
    if (!RST && tag_we) tag_q[req_idx] <= req_tag;
  end
endmodule

// File: tb/tb_cache_ctrl_wb.sv
// Directed bench for cache_ctrl_wb: request vector table plus flush and reset-abort sequences
// against a word-addressed memory model with programmable ack wait states.
module tb_cache_ctrl_wb;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_ready, cpu_done;
  logic [31:0] cpu_rdata;
  logic        flush_req = 1'b0, flush_done;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] stat_hits, stat_misses;

  always #5 CLK = ~CLK;

  cache_ctrl_wb #(.ADDR_W(32), .LINES(16), .WORDS_PER_LINE(4)) dut (
    .CLK(CLK), .RST(RST),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .flush_req(flush_req), .flush_done(flush_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [1024];
  int          wait_n = 0;
  int          wcnt   = 0;
  logic        pend   = 1'b0;
  logic [31:0] pend_addr = '0;
  logic [31:0] rd_log [$];
  logic [31:0] wr_log [$];
  logic [31:0] wd_log [$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          min_lat;
    int          wait_n;
    int          exp_rdb;
    logic [31:0] rbase;
    int          exp_wrb;
    logic [31:0] wbase;
    logic [31:0] wd1;
    int          hits;
    int          misses;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  // Memory model: decides ack at the falling edge so the DUT sees it at the next rising edge
  always @(negedge CLK) begin
    if (mem_req && !RST) begin
      if (pend) chk("mem_addr_stable", mem_addr, pend_addr);
      if (wcnt >= wait_n) begin
        mem_ack = 1'b1;
        wcnt    = 0;
        pend    = 1'b0;
        if (mem_we) begin
          mem[mem_addr[11:2]] = mem_wdata;
          wr_log.push_back(mem_addr);
          wd_log.push_back(mem_wdata);
        end else begin
          mem_rdata = mem[mem_addr[11:2]];
          rd_log.push_back(mem_addr);
        end
      end else begin
        mem_ack   = 1'b0;
        wcnt++;
        pend      = 1'b1;
        pend_addr = mem_addr;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
      pend    = 1'b0;
    end
  end

  task automatic clear_logs();
    rd_log.delete();
    wr_log.delete();
    wd_log.delete();
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int guard;
    int lat;
    logic [31:0] rdata;
    clear_logs();
    wait_n    = v.wait_n;
    cpu_we    = v.we;
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    cpu_req   = 1'b1;
    guard = 0;
    while (!cpu_ready && guard < 50) begin
      step();
      guard++;
    end
    chk({tag, " accept"}, 32'(cpu_ready), 32'd1);
    step();
    cpu_req = 1'b0;
    lat = 1;
    while (!cpu_done && lat < 300) begin
      step();
      lat++;
    end
    rdata = cpu_rdata;
    chk({tag, " done"}, 32'(cpu_done), 32'd1);
    if (v.chk_rd) chk({tag, " rdata"}, rdata, v.exp_rd);
    if (v.exp_lat != 0) chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    if (v.min_lat != 0) begin
      n_tests++;
      if (lat < v.min_lat) begin
        n_fail++;
        $display("FAIL %s min_latency: got %0d cycles required >= %0d", tag, lat, v.min_lat);
      end
    end
    step();
    chk({tag, " stat_hits"}, stat_hits, 32'(v.hits));
    chk({tag, " stat_misses"}, stat_misses, 32'(v.misses));
    chk({tag, " read_beats"}, 32'(rd_log.size()), 32'(v.exp_rdb));
    chk({tag, " write_beats"}, 32'(wr_log.size()), 32'(v.exp_wrb));
    for (int k = 0; k < v.exp_rdb && k < rd_log.size(); k++)
      chk($sformatf("%s rd_addr%0d", tag, k), rd_log[k], v.rbase + 32'(4 * k));
    for (int k = 0; k < v.exp_wrb && k < wr_log.size(); k++)
      chk($sformatf("%s wr_addr%0d", tag, k), wr_log[k], v.wbase + 32'(4 * k));
    if (v.exp_wrb == 4 && wd_log.size() >= 2) chk({tag, " wr_data1"}, wd_log[1], v.wd1);
  endtask

  initial begin
    int guard;
    int fd_cnt;
    logic cd_seen;
    logic order_ok;
    logic [31:0] rdata;
    vec_t v;

    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int fd_cnt;
    logic cd_seen;
    logic order_ok;
    logic [31:0] rdata;
    vec_t v;

    for (int i = 0; i < 1024; i++) mem[i] = 32'(i * 4);

    //          we    addr          wdata          chk   exp_rd         lat min wt rdb rbase       wrb wbase       wd1            h  m
    vecs[0]  = '{1'b0, 32'h100, 32'h0,          1'b1, 32'h100,       0,  0, 0, 4, 32'h100, 0, 32'h0,   32'h0,          0, 1};
    vecs[1]  = '{1'b0, 32'h104, 32'h0,          1'b1, 32'h104,       1,  0, 0, 0, 32'h0,   0, 32'h0,   32'h0,          1, 1};
    vecs[2]  = '{1'b1, 32'h104, 32'hDEADBEEF,   1'b0, 32'h0,         1,  0, 0, 0, 32'h0,   0, 32'h0,   32'h0,          2, 1};
    vecs[3]  = '{1'b0, 32'h504, 32'h0,          1'b1, 32'h504,       0,  0, 0, 4, 32'h500, 4, 32'h100, 32'hDEADBEEF,   2, 2};
    vecs[4]  = '{1'b0, 32'h104, 32'h0,          1'b1, 32'hDEADBEEF,  0,  0, 0, 4, 32'h100, 0, 32'h0,   32'h0,          2, 3};
    vecs[5]  = '{1'b1, 32'h008, 32'h12345678,   1'b0, 32'h0,         0,  0, 0, 4, 32'h000, 0, 32'h0,   32'h0,          2, 4};
    vecs[6]  = '{1'b0, 32'h008, 32'h0,          1'b1, 32'h12345678,  1,  0, 0, 0, 32'h0,   0, 32'h0,   32'h0,          3, 4};
    vecs[7]  = '{1'b0, 32'h00C, 32'h0,          1'b1, 32'h00C,       1,  0, 0, 0, 32'h0,   0, 32'h0,   32'h0,          4, 4};
    vecs[8]  = '{1'b0, 32'h214, 32'h0,          1'b1, 32'h214,       0, 12, 2, 4, 32'h210, 0, 32'h0,   32'h0,          4, 5};
    vecs[9]  = '{1'b1, 32'h0F4, 32'hCAFEF00D,   1'b0, 32'h0,         0,  0, 0, 4, 32'h0F0, 0, 32'h0,   32'h0,          4, 6};
    vecs[10] = '{1'b0, 32'h0F4, 32'h0,          1'b1, 32'hCAFEF00D,  1,  0, 0, 0, 32'h0,   0, 32'h0,   32'h0,          5, 6};

    // Reset state
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("reset cpu_ready", 32'(cpu_ready), 32'd1);
    chk("reset cpu_done", 32'(cpu_done), 32'd0);
    chk("reset flush_done", 32'(flush_done), 32'd0);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset stat_hits", stat_hits, 32'd0);
    chk("reset stat_misses", stat_misses, 32'd0);

    for (int i = 0; i < 11; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Flush and CPU request raised together: flush must finish first
    clear_logs();
    wait_n    = 0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h008;
    cpu_req   = 1'b1;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    chk("flush blocks cpu_ready", 32'(cpu_ready), 32'd0);
    fd_cnt   = 0;
    cd_seen  = 1'b0;
    order_ok = 1'b1;
    rdata    = '0;
    guard    = 0;
    while (!cd_seen && guard < 500) begin
      step();
      guard++;
      if (flush_done) fd_cnt++;
      if (cpu_done) begin
        cd_seen = 1'b1;
        rdata   = cpu_rdata;
        if (fd_cnt == 0) order_ok = 1'b0;
      end
    end
    cpu_req = 1'b0;
    chk("flush cpu_done seen", 32'(cd_seen), 32'd1);
    chk("flush before cpu", 32'(order_ok), 32'd1);
    chk("flush_done pulses", 32'(fd_cnt), 32'd1);
    chk("flush write beats", 32'(wr_log.size()), 32'd8);
    for (int k = 0; k < 8 && k < wr_log.size(); k++)
      chk($sformatf("flush wr_addr%0d", k), wr_log[k],
          (k < 4) ? 32'(4 * k) : 32'h0F0 + 32'(4 * (k - 4)));
    if (wd_log.size() >= 6) begin
      chk("flush wr_data 0x008", wd_log[2], 32'h12345678);
      chk("flush wr_data 0x0F4", wd_log[5], 32'hCAFEF00D);
    end
    chk("post-flush load rdata", rdata, 32'h12345678);
    chk("post-flush read beats", 32'(rd_log.size()), 32'd4);
    if (rd_log.size() >= 1) chk("post-flush rd_addr0", rd_log[0], 32'h000);
    step();
    chk("post-flush stat_misses", stat_misses, 32'd7);
    chk("post-flush stat_hits", stat_hits, 32'd5);

    // Reset while the second refill beat is being acknowledged
    clear_logs();
    wait_n   = 0;
    cpu_we   = 1'b0;
    cpu_addr = 32'h304;
    cpu_req  = 1'b1;
    guard    = 0;
    while (rd_log.size() < 2 && guard < 50) begin
      step();
      guard++;
    end
    chk("abort reached beat 2", 32'(rd_log.size()), 32'd2);
    RST     = 1'b1;
    cpu_req = 1'b0;
    step();
    chk("abort mem_req", 32'(mem_req), 32'd0);
    chk("abort cpu_ready", 32'(cpu_ready), 32'd1);
    chk("abort cpu_done", 32'(cpu_done), 32'd0);
    chk("abort stat_misses", stat_misses, 32'd0);
    RST = 1'b0;
    step();
    v = '{1'b0, 32'h304, 32'h0, 1'b1, 32'h304, 0, 0, 0, 4, 32'h300, 0, 32'h0, 32'h0, 0, 1};
    run_vec("reload after abort", v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_ctrl_wb.md
Name: cache_ctrl_wb

Overview:
- Parametrised write-back, write-allocate, direct-mapped data-cache controller for the OTTER memory system.
- Holds tag, valid and dirty arrays plus a register-based data array.
- Services one-word CPU load/store requests, and fills or evicts whole lines over a word-beat memory handshake.
- Adds two things the first-generation controller lacks: dirty-line writeback and a full-cache flush walk. Provides hit/miss statistics counters.

Parameters:
- ADDR_W, 32, byte-address width.
- LINES, 16, number of lines; power of 2, minimum 2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of 2, minimum 2.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- cpu_req  in  1  request valid.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- cpu_wdata  in  32  store data.
- cpu_ready  out  1  controller can accept a request (ps == IDLE and flush_req == 0).
- cpu_done  out  1  one-cycle pulse: request complete.
- cpu_rdata  out  32  load data; valid while cpu_done = 1.
- flush_req  in  1  request writeback and invalidate of every line.
- flush_done  out  1  one-cycle pulse at flush completion.
- mem_req  out  1  memory beat request.
- mem_we  out  1  1 = beat write, 0 = beat read.
- mem_addr  out  ADDR_W  word-aligned beat address.
- mem_wdata  out  32  beat write data.
- mem_rdata  in  32  beat read data; valid with mem_ack.
- mem_ack  in  1  beat accepted/completed; ignored when mem_req = 0.
- stat_hits  out  32  hit counter; saturates at 0xFFFFFFFF.
- stat_misses  out  32  miss counter; saturates at 0xFFFFFFFF.

Behaviour:
- Address split: [1:0] byte offset, then word offset (log2 WORDS_PER_LINE bits), then index (log2 LINES bits), remaining upper bits = tag.
- Reset: ps = IDLE; all valid and dirty bits = 0; beat counter = 0; stat_hits = stat_misses = 0. Outputs after reset: cpu_done = 0, flush_done = 0, mem_req = 0, mem_we = 0, cpu_ready = 1. Data/tag array contents are don't-care.
- Reset mid-operation (any state) aborts the operation immediately. No partial line is marked valid. mem_req is 0 in the cycle after the reset edge.
- States: IDLE, TAG_CHECK, WRITEBACK, REFILL, FLUSH_SCAN, FLUSH_WB.
- IDLE:
  - flush_req = 1 has priority: line index counter = 0, go to FLUSH_SCAN.
  - Else cpu_req = 1: latch addr/we/wdata, go to TAG_CHECK.
- TAG_CHECK, hit (valid and tag match):
  - cpu_done = 1 this cycle; cpu_rdata = addressed word (combinational from array).
  - Store: writes the word and sets dirty at the end of this cycle.
  - stat_hits increments, except on the re-check that follows a refill.
  - Next state IDLE.
  - Hit latency: accept edge plus 1 cycle, so one request completes every 2 cycles.
- TAG_CHECK, miss:
  - stat_misses increments.
  - Go to WRITEBACK if the line is valid and dirty, else to REFILL. Beat counter = 0.
- WRITEBACK:
  - mem_req = 1, mem_we = 1.
  - mem_addr = {old tag, index, beat, 2'b00}; mem_wdata = line word[beat].
  - Address and data stay stable until mem_ack; beat increments on each ack.
  - Ack of the last beat: beat = 0, go to REFILL.
- REFILL:
  - mem_req = 1, mem_we = 0; mem_addr = {new tag, index, beat, 2'b00}.
  - On mem_ack: word[beat] = mem_rdata, beat increments.
  - Ack of the last beat: tag = new tag, valid = 1, dirty = 0, go to TAG_CHECK (guaranteed hit).
- Zero-wait memory (ack in the same cycle mem_req rises) is legal, giving 1 beat per cycle.
- FLUSH_SCAN:
  - If line[idx] is valid and dirty: beat = 0, go to FLUSH_WB.
  - Else: clear valid[idx]. If idx is the last line, flush_done = 1 and go to IDLE; otherwise idx increments and stay.
- FLUSH_WB:
  - Same beat protocol as WRITEBACK, using line[idx].
  - After the last ack: valid = dirty = 0, then the same idx-advance/last-line logic as FLUSH_SCAN.
- flush_req is sampled only in IDLE. Holding it high after completion starts another flush.
- cpu_req outside IDLE is ignored; the CPU holds it until cpu_ready.
- Counters saturate and do not wrap.

Test Plan:
- Read miss then hit: after reset, load 0x100 with memory returning word = address → REFILL issues beat reads at 0x100, 0x104, 0x108, 0x10C. cpu_rdata = 0x100; stat_misses = 1. A following load of 0x104 completes 1 cycle after accept with 0x104; stat_hits = 1.
- Write hit then eviction: store 0xDEADBEEF to 0x104, then load 0x504 (same index, LINES = 16) → 4 write beats from 0x100 with the 2nd beat = 0xDEADBEEF, then refill from 0x500; stat_misses = 2.
- Memory wait states: ack every 3rd cycle during refill → mem_addr stays stable between acks; completion takes 12+ cycles; data is correct.
- Flush: dirty lines at indices 0 and 15, then pulse flush_req → exactly 8 write beats (0x000–0x00C and the index-15 line). flush_done pulses once. A later load of 0x000 misses.
- Simultaneous flush_req and cpu_req in IDLE → flush runs first; the CPU request is accepted only after flush_done.
- RST asserted during the 2nd refill beat → next cycle mem_req = 0 and cpu_ready = 1. Reloading the same address misses (the line was not marked valid).
